// File: rtl/fxp_pkg.sv
// Shared definitions for the fixed-point adder arbiter: FSM encoding and default formats.
package fxp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam int DEF_NREQ = 4;
    localparam int DEF_IDW  = 2;
    localparam int DEF_WI1  = 8;
    localparam int DEF_WF1  = 8;
    localparam int DEF_WI2  = 8;
    localparam int DEF_WF2  = 8;
    localparam int DEF_WIO  = 11;
    localparam int DEF_WFO  = 8;
    localparam int DEF_OCW  = 16;

endpackage

// File: rtl/FixedPoint_Adder.sv
// Signed fixed-point adder: aligns fractions, sums exactly, then truncates/wraps to WIO.WFO
// and flags sums whose integer part does not fit in WIO bits.
module FixedPoint_Adder #(
    parameter int WI1 = 8,
    parameter int WF1 = 8,
    parameter int WI2 = 8,
    parameter int WF2 = 8,
    parameter int WIO = 11,
    parameter int WFO = 8
) (
    input  logic [WI1+WF1-1:0] in1,
    input  logic [WI2+WF2-1:0] in2,
    output logic [WIO+WFO-1:0] FixedPoint_Add_Out,
    output logic               overFlow
);
    localparam int WFM = (WF1 > WF2) ? WF1 : WF2;
    localparam int FW  = (WFM > WFO) ? WFM : WFO;
    localparam int WIM = ((WI1 > WI2) ? WI1 : WI2) + 1;
    localparam int IW  = (WIM > WIO) ? WIM : WIO;
    localparam int W   = IW + FW;

    logic [W-1:0]            a_ext;
    logic [W-1:0]            b_ext;
    logic [W-1:0]            sum;
    logic [W-FW-WIO:0]       top;

    // The working width holds the exact sum, so only the final narrowing can overflow.
    assign a_ext = W'(signed'(in1)) << (FW - WF1);
    assign b_ext = W'(signed'(in2)) << (FW - WF2);
    assign sum   = a_ext + b_ext;

    assign FixedPoint_Add_Out = sum[FW-WFO +: WIO+WFO];
    assign top                = sum[W-1:FW+WIO-1];
    assign overFlow           = !((&top) || (~|top));

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant: first set request bit searching circularly upward from ptr.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  gidx
);
    logic           found;
    logic [IDW-1:0] idx;

    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            // IDW-bit addition wraps naturally since NREQ is a power of two.
            idx = ptr + IDW'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                gidx  = idx;
            end
        end
        if (found) grant[gidx] = 1'b1;
    end

endmodule

// File: rtl/fixedpoint_add_arbiter.sv
// Shares one FixedPoint_Adder among NREQ requesters with round-robin arbitration,
// a held result port and a saturating overflow counter.
module fixedpoint_add_arbiter
    import fxp_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = DEF_IDW,
    parameter int WI1  = DEF_WI1,
    parameter int WF1  = DEF_WF1,
    parameter int WI2  = DEF_WI2,
    parameter int WF2  = DEF_WF2,
    parameter int WIO  = DEF_WIO,
    parameter int WFO  = DEF_WFO,
    parameter int OCW  = DEF_OCW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*(WI1+WF1)-1:0] req_in1,
    input  logic [NREQ*(WI2+WF2)-1:0] req_in2,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [WIO+WFO-1:0]     res_data,
    output logic [IDW-1:0]         res_id,
    output logic                   res_ovf,
    output logic                   busy,
    output logic [OCW-1:0]         ovf_cnt
);
    localparam int W1 = WI1 + WF1;
    localparam int W2 = WI2 + WF2;
    localparam int WO = WIO + WFO;

    state_t          state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q;
    logic [IDW-1:0]  gidx_q;
    logic [W1-1:0]   op1_q;
    logic [W2-1:0]   op2_q;
    logic            res_valid_q;
    logic [WO-1:0]   res_data_q;
    logic [IDW-1:0]  res_id_q;
    logic            res_ovf_q;
    logic [OCW-1:0]  ovf_cnt_q;

    logic [NREQ-1:0] arb_grant;
    logic [IDW-1:0]  arb_idx;
    logic [W1-1:0]   sel_in1;
    logic [W2-1:0]   sel_in2;
    logic [WO-1:0]   add_out;
    logic            add_ovf;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (arb_grant),
        .gidx  (arb_idx)
    );

    FixedPoint_Adder #(
        .WI1 (WI1),
        .WF1 (WF1),
        .WI2 (WI2),
        .WF2 (WF2),
        .WIO (WIO),
        .WFO (WFO)
    ) u_add (
        .in1                (op1_q),
        .in2                (op2_q),
        .FixedPoint_Add_Out (add_out),
        .overFlow           (add_ovf)
    );

    always_comb begin
        sel_in1 = '0;
        sel_in2 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_idx == IDW'(i)) begin
                sel_in1 = req_in1[i*W1 +: W1];
                sel_in2 = req_in2[i*W2 +: W2];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (|req_valid) state_d = ST_ADD;
            ST_ADD:  state_d = ST_HOLD;
            ST_HOLD: if (res_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == ST_IDLE) ? arb_grant : '0;
        busy      = (state_q != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            gidx_q      <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
            res_ovf_q   <= 1'b0;
            ovf_cnt_q   <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (|req_valid) begin
                        op1_q    <= sel_in1;
                        op2_q    <= sel_in2;
                        gidx_q   <= arb_idx;
                        rr_ptr_q <= arb_idx + IDW'(1);
                    end
                end
                ST_ADD: begin
                    res_data_q  <= add_out;
                    res_ovf_q   <= add_ovf;
                    res_id_q    <= gidx_q;
                    res_valid_q <= 1'b1;
                    if (add_ovf && !(&ovf_cnt_q)) ovf_cnt_q <= ovf_cnt_q + OCW'(1);
                end
                ST_HOLD: begin
                    if (res_ready) res_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign res_ovf   = res_ovf_q;
    assign ovf_cnt   = ovf_cnt_q;

endmodule

// File: doc/fixedpoint_add_arbiter.md
Name: fixedpoint_add_arbiter

Overview:
- Shares one FixedPoint_Adder instance between NREQ requesters.
- Each requester offers an operand pair over a valid/ready handshake.
- A round-robin arbiter grants one requester at a time. The operands are registered and summed, and the result is returned with the requester ID and overflow flag over a valid/ready result port.
- A saturating overflow counter supports datapath monitoring.

Parameters:
- NREQ, 4: number of requesters; ≥2, power of two.
- IDW, 2: requester ID width; equals log2(NREQ).
- WI1, 8: operand-1 integer bits, sign included.
- WF1, 8: operand-1 fraction bits.
- WI2, 8: operand-2 integer bits.
- WF2, 8: operand-2 fraction bits.
- WIO, 11: result integer bits.
- WFO, 8: result fraction bits.
- OCW, 16: overflow counter width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  bit i set: requester i presents operands.
- req_ready  out  NREQ  one-hot grant; bit i set: requester i accepted this cycle.
- req_in1  in  NREQ*(WI1+WF1)  requester i's operand 1 in slice i, signed two's complement.
- req_in2  in  NREQ*(WI2+WF2)  requester i's operand 2 in slice i.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_data  out  WIO+WFO  registered adder sum.
- res_id  out  IDW  index of the requester that owns res_data.
- res_ovf  out  1  registered adder overFlow for this result.
- busy  out  1  high whenever state is not IDLE.
- ovf_cnt  out  OCW  count of overflowed results, saturating.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, rr_ptr=0.
  - req_ready=0, res_valid=0, res_data=0, res_id=0, res_ovf=0, busy=0, ovf_cnt=0.
  - Any in-flight operation is dropped and no result is emitted.
  - Reset takes priority over every other event.
- State machine, states IDLE, ADD, HOLD:
  - IDLE: req_ready = grant when req_valid≠0, else 0.
    - grant = first set bit of req_valid, searching circularly from rr_ptr upward.
    - On an edge with any req_valid: capture the granted requester's in1/in2 into op registers, latch gidx, set rr_ptr=(gidx+1) mod NREQ, go to ADD.
  - ADD: req_ready=0. At the edge, register adder FixedPoint_Add_Out into res_data, overFlow into res_ovf, gidx into res_id. Set res_valid=1 and go to HOLD.
    - If overFlow=1 and ovf_cnt≠all-ones, increment ovf_cnt.
  - HOLD: req_ready=0. res_valid=1 and res_data/res_id/res_ovf stay stable until res_ready=1.
    - On the edge with res_ready=1: res_valid=0, go to IDLE.
- Latency:
  - Request accepted at edge T; res_valid rises after edge T+1.
  - Minimum 3 cycles per operation, since IDLE is always visited between operations.
- Requester handshake:
  - A requester holds valid and operands until it sees its ready bit.
  - Deasserting valid before grant is legal; that requester is simply skipped.
  - req_ready is never asserted in ADD or HOLD.
- Arithmetic: fully delegated to FixedPoint_Adder.
  - Operands are fraction-aligned and sign-extended.
  - The sum is truncated/wrapped to WIO.WFO.
  - overFlow=1 when the exact sum is not representable in WIO integer bits.
  - This block never modifies res_data.
- res_ready while res_valid=0 is ignored.
- Boundary conditions:
  - All requesters valid: grants rotate 0,1,2,3,0, …
  - Only requester i valid: it is granted back-to-back, one grant per 3 cycles.
  - rr_ptr wraps from NREQ-1 to 0.
  - ovf_cnt saturates at 2^OCW-1 and never wraps.
  - rst asserted in ADD or HOLD: outputs clear at that edge; the result is lost.

Decomposition:
- Shared package fxp_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_ADD=2'd1, ST_HOLD=2'd2;
  - the default format constants.
- Sub-modules:
  - Round-robin grant logic is a sub-module, rr_arbiter (inputs req, ptr; output one-hot grant, gidx).
  - The existing FixedPoint_Adder is instantiated unchanged with pass-through parameters.

Test Plan:
1. Reset mid-HOLD:
   - Stimulus: start an operation; in HOLD with res_ready=0, pulse rst.
   - Required: next cycle res_valid=0, busy=0, ovf_cnt=0, rr_ptr=0; no stray result.
2. Single requester:
   - Stimulus: req0 in1=0x0180, in2=0x0180 (1.5+1.5), res_ready=1.
   - Required: req_ready[0] for 1 cycle; 2 cycles later res_valid=1, res_data=19'h00300 (3.0), res_id=0, res_ovf=0.
3. Round-robin fairness:
   - Stimulus: all four requesters valid continuously, res_ready=1.
   - Required: res_id sequence 0,1,2,3,0,1; a result every 3 cycles.
4. Backpressure:
   - Stimulus: res_ready=0 for 10 cycles after res_valid rises.
   - Required: res_data/res_id stable, req_ready=0 throughout; one result delivered on release.
5. Overflow:
   - Stimulus: WIO=8 instance; in1=in2=0x7F00 (127.0).
   - Required: res_ovf=1, ovf_cnt increments to 1.
   - Stimulus: OCW=2 with 5 overflowing operations.
   - Required: ovf_cnt=3.
6. Sparse/withdrawn requests:
   - Stimulus: rr_ptr=2, req_valid=4'b0011.
   - Required: grant to 0 (circular wrap), then rr_ptr=1.
   - Stimulus: req1 withdraws valid before its turn.
   - Required: req1 is skipped.
